// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding and fixed field widths.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_t;

  localparam int LUT_IDX_W = 4;
  localparam int ACC_W     = 8;

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// Writable branch-target table: async-cleared register array, combinational read,
// separate low-byte / high-part writes sourced from the accumulator.
module branch_lut
  import fetch_unit_pkg::*;
#(
  parameter int PC_W      = 10,
  parameter int LUT_DEPTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 we_i,
  input  logic                 hi_i,
  input  logic [LUT_IDX_W-1:0] idx_i,
  input  logic [ACC_W-1:0]     data_i,
  output logic [PC_W-1:0]      rdata_o
);

  logic [PC_W-1:0] lut_q [LUT_DEPTH];

  // Indices at or above LUT_DEPTH match no entry: writes drop, reads give 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        lut_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        if (idx_i == LUT_IDX_W'(i)) begin
          if (hi_i) begin
            lut_q[i][PC_W-1:8] <= (PC_W-8)'(data_i);
          end else begin
            lut_q[i][7:0] <= data_i;
          end
        end
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < LUT_DEPTH; i++) begin
      if (idx_i == LUT_IDX_W'(i)) begin
        rdata_o = lut_q[i];
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Program-counter / fetch stage with branch LUT and run/halt sequencing.
// Define FETCH_BRANCH_REL_EN to treat LUT entries as signed PC-relative offsets.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_W       = 10,
  parameter int LUT_DEPTH  = 16,
  parameter int START_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 Start,
  input  logic                 Ack,
  input  logic                 PC_Jmp_Flag,
  input  logic                 PC_Beq_Flag,
  input  logic                 LUT_Read_En,
  input  logic                 LUT_Write_En,
  input  logic                 LUT_Load_Hi,
  input  logic [LUT_IDX_W-1:0] LUT_Idx,
  input  logic [ACC_W-1:0]     AccInput,
  output logic [PC_W-1:0]      Prog_Ctr,
  output logic                 Instr_Valid,
  output logic                 Done,
  output logic [CNT_W-1:0]     Cycle_Cnt
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0] lut_rdata;
  logic [PC_W-1:0] br_target;
  logic            br_take;

  branch_lut #(
    .PC_W      (PC_W),
    .LUT_DEPTH (LUT_DEPTH)
  ) u_lut (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .we_i    (LUT_Write_En),
    .hi_i    (LUT_Load_Hi),
    .idx_i   (LUT_Idx),
    .data_i  (AccInput),
    .rdata_o (lut_rdata)
  );

`ifdef FETCH_BRANCH_REL_EN
  assign br_target = pc_q + lut_rdata;
`else
  assign br_target = lut_rdata;
`endif

  assign br_take = (PC_Jmp_Flag | PC_Beq_Flag) & LUT_Read_En;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= FS_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Start restarts from any state; Ack outranks a branch in the same cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      FS_IDLE, FS_HALT: begin
        if (Start) begin
          state_d = FS_RUN;
          pc_d    = START_PC;
          cnt_d   = '0;
        end
      end
      FS_RUN: begin
        if (Start) begin
          pc_d  = START_PC;
          cnt_d = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
          if (Ack) begin
            state_d = FS_HALT;
          end else if (br_take) begin
            pc_d = br_target;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      default: begin
        state_d = FS_IDLE;
      end
    endcase
  end

  assign Prog_Ctr    = pc_q;
  assign Instr_Valid = (state_q == FS_RUN);
  assign Done        = (state_q == FS_HALT);
  assign Cycle_Cnt   = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit against a cycle-level behavioural model.
module tb_fetch_unit;

  localparam int PC_W     = 10;
  localparam int DEPTH    = 12;
  localparam int START    = 0;
  localparam int CNT_W    = 4;
  localparam int PC_RANGE = 1 << PC_W;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef FETCH_BRANCH_REL_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  logic             Clk;
  logic             Reset_n;
  logic             Start, Ack, PC_Jmp_Flag, PC_Beq_Flag;
  logic             LUT_Read_En, LUT_Write_En, LUT_Load_Hi;
  logic [3:0]       LUT_Idx;
  logic [7:0]       AccInput;
  logic [PC_W-1:0]  Prog_Ctr;
  logic             Instr_Valid, Done;
  logic [CNT_W-1:0] Cycle_Cnt;

  int checks = 0;
  int errors = 0;

  int pc_m, cnt_m;
  bit running, halted;
  int lut_m [16];

  fetch_unit #(
    .PC_W       (PC_W),
    .LUT_DEPTH  (DEPTH),
    .START_ADDR (START),
    .CNT_W      (CNT_W)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Start        (Start),
    .Ack          (Ack),
    .PC_Jmp_Flag  (PC_Jmp_Flag),
    .PC_Beq_Flag  (PC_Beq_Flag),
    .LUT_Read_En  (LUT_Read_En),
    .LUT_Write_En (LUT_Write_En),
    .LUT_Load_Hi  (LUT_Load_Hi),
    .LUT_Idx      (LUT_Idx),
    .AccInput     (AccInput),
    .Prog_Ctr     (Prog_Ctr),
    .Instr_Valid  (Instr_Valid),
    .Done         (Done),
    .Cycle_Cnt    (Cycle_Cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"},   32'(Prog_Ctr),    32'(pc_m));
    chk({tag, ".vld"},  32'(Instr_Valid), 32'(running));
    chk({tag, ".done"}, 32'(Done),        32'(halted));
    chk({tag, ".cnt"},  32'(Cycle_Cnt),   32'(cnt_m));
  endtask

  task automatic model_reset();
    pc_m = 0; cnt_m = 0; running = 0; halted = 0;
    for (int i = 0; i < 16; i++) lut_m[i] = 0;
  endtask

  // One clock edge of the reference behaviour, using the inputs currently applied.
  task automatic model_step();
    int idx, rd, tgt;
    idx = int'(LUT_Idx);
    rd  = (idx < DEPTH) ? lut_m[idx] : 0;
    tgt = REL ? (pc_m + rd) % PC_RANGE : rd;
    if (running) begin
      if (Start) begin
        pc_m = START; cnt_m = 0;
      end else begin
        cnt_m = (cnt_m < CNT_MAX) ? cnt_m + 1 : CNT_MAX;
        if (Ack) begin
          running = 0; halted = 1;
        end else if ((PC_Jmp_Flag || PC_Beq_Flag) && LUT_Read_En) begin
          pc_m = tgt;
        end else begin
          pc_m = (pc_m + 1) % PC_RANGE;
        end
      end
    end else if (Start) begin
      running = 1; halted = 0; pc_m = START; cnt_m = 0;
    end
    if (LUT_Write_En && idx < DEPTH) begin
      if (LUT_Load_Hi) lut_m[idx] = (lut_m[idx] & 'hFF) | ((int'(AccInput) & 'h3) << 8);
      else             lut_m[idx] = (lut_m[idx] & 'h300) | int'(AccInput);
    end
  endtask

  task automatic cyc(input string tag, input logic st, input logic ack, input logic jmp,
                     input logic beq, input logic rden, input logic we, input logic hi,
                     input logic [3:0] idx, input logic [7:0] acc);
    Start = st; Ack = ack; PC_Jmp_Flag = jmp; PC_Beq_Flag = beq;
    LUT_Read_En = rden; LUT_Write_En = we; LUT_Load_Hi = hi;
    LUT_Idx = idx; AccInput = acc;
    @(posedge Clk);
    model_step();
    @(negedge Clk);
    chk_all(tag);
  endtask

  initial begin
    Reset_n = 1'b0;
    Start = 0; Ack = 0; PC_Jmp_Flag = 0; PC_Beq_Flag = 0;
    LUT_Read_En = 0; LUT_Write_En = 0; LUT_Load_Hi = 0;
    LUT_Idx = '0; AccInput = '0;
    model_reset();
    repeat (2) @(negedge Clk);
    chk_all("reset");
    Reset_n = 1'b1;

    cyc("idle",  0, 0, 1, 0, 1, 0, 0, 4'd0, 8'h00);
    cyc("start", 1, 0, 0, 0, 0, 0, 0, 4'd0, 8'h00);
    for (int i = 0; i < 3; i++) cyc("seq", 0, 0, 0, 0, 0, 0, 0, 4'd0, 8'h00);

    cyc("wr5lo", 0, 0, 0, 0, 0, 1, 0, 4'd5, 8'h34);
    cyc("wr5hi", 0, 0, 0, 0, 0, 1, 1, 4'd5, 8'h02);
    cyc("jmp5",  0, 0, 1, 0, 1, 0, 0, 4'd5, 8'h00);
    cyc("beq0",  0, 0, 0, 0, 1, 0, 0, 4'd5, 8'h00);
    cyc("beq1",  0, 0, 0, 1, 1, 0, 0, 4'd5, 8'h00);
    cyc("nord",  0, 0, 1, 0, 0, 0, 0, 4'd5, 8'h00);

    cyc("wr3old", 0, 0, 1, 0, 1, 1, 0, 4'd3, 8'h55);
    cyc("rd3new", 0, 0, 1, 0, 1, 0, 0, 4'd3, 8'h00);

    cyc("wr7lo", 0, 0, 0, 0, 0, 1, 0, 4'd7, 8'hFF);
    cyc("wr7hi", 0, 0, 0, 0, 0, 1, 1, 4'd7, 8'h03);
    cyc("jmp7",  0, 0, 1, 0, 1, 0, 0, 4'd7, 8'h00);
    cyc("wrap",  0, 0, 0, 0, 0, 0, 0, 4'd0, 8'h00);

    cyc("wr14",  0, 0, 0, 0, 0, 1, 0, 4'd14, 8'hAA);
    cyc("jmp14", 0, 0, 1, 0, 1, 0, 0, 4'd14, 8'h00);

    cyc("ackjmp", 0, 1, 1, 0, 1, 0, 0, 4'd5, 8'h00);
    cyc("halt1",  0, 1, 1, 1, 1, 0, 0, 4'd5, 8'h00);
    cyc("halt2",  0, 0, 0, 0, 0, 0, 0, 4'd0, 8'h00);
    cyc("restart", 1, 0, 0, 0, 0, 0, 0, 4'd0, 8'h00);

    for (int i = 0; i < 400; i++) begin
      cyc("rand", ($urandom_range(39) == 0), ($urandom_range(29) == 0),
          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          4'($urandom), 8'($urandom));
    end

    cyc("satstart", 1, 0, 0, 0, 0, 0, 0, 4'd0, 8'h00);
    for (int i = 0; i < CNT_MAX + 4; i++) cyc("sat", 0, 0, 0, 0, 0, 0, 0, 4'd0, 8'h00);

    Reset_n = 1'b0;
    #1;
    model_reset();
    chk_all("async_rst");
    @(negedge Clk);
    Reset_n = 1'b1;
    cyc("post_rst_start", 1, 0, 0, 0, 0, 0, 0, 4'd0, 8'h00);
    cyc("post_rst_jmp",   0, 0, 1, 0, 1, 0, 0, 4'd5, 8'h00);
    cyc("post_rst_jmp7",  0, 0, 1, 0, 1, 0, 0, 4'd7, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
